bi_rot_pipe: RTL and testbench

BI_ROT_PIPE -- requirements
Module: bi_rot_pipe

---
 rtl/bi_rot_pkg.sv | 37 +++
 rtl/bi_rot_half.sv | 27 ++
 rtl/bi_rot_pipe.sv | 129 ++++++++++++
 tb/tb_bi_rot_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bi_rot_pkg.sv
// Shared types and helpers for the bit-interleaved lane rotator.
// A lane holds a logical word x; in interleaved layout the low half of the
// lane carries the even bits of x and the high half carries the odd bits.
package bi_rot_pkg;

    typedef enum logic {
        ROT_R = 1'b0,
        ROT_L = 1'b1
    } dir_e;

    localparam int MAX_LANE_W = 128;

    // Logical word -> interleaved lane (low half = even bits, high half = odd bits).
    function automatic logic [MAX_LANE_W-1:0] interleave(input logic [MAX_LANE_W-1:0] x,
                                                         input int width);
        logic [MAX_LANE_W-1:0] lane;
        lane = '0;
        for (int i = 0; i < width / 2; i++) begin
            lane[i]             = x[2*i];
            lane[width / 2 + i] = x[2*i+1];
        end
        return lane;
    endfunction

    // Interleaved lane -> logical word.
    function automatic logic [MAX_LANE_W-1:0] deinterleave(input logic [MAX_LANE_W-1:0] lane,
                                                           input int width);
        logic [MAX_LANE_W-1:0] x;
        x = '0;
        for (int i = 0; i < width / 2; i++) begin
            x[2*i]   = lane[i];
            x[2*i+1] = lane[width / 2 + i];
        end
        return x;
    endfunction

endpackage

// File: rtl/bi_rot_half.sv
// Combinational right barrel rotator of parametrised width (power of two).
module bi_rot_half #(
    parameter int W = 32
) (
    input  logic [W-1:0]         din,
    input  logic [$clog2(W)-1:0] amt,
    output logic [W-1:0]         dout
);

    localparam int AW = $clog2(W);

    logic [W-1:0] acc;

    // Log-depth rotate: stage k rotates right by 2**k when amt[k] is set.
    always_comb begin
        // NOTE: blocking assignments here chain the stages within one evaluation;
        // acc is written on every path, so no latch is inferred.
        acc = din;
        for (int k = 0; k < AW; k++) begin
            if (amt[k]) begin
                acc = (acc >> (1 << k)) | (acc << (W - (1 << k)));
            end
        end
        dout = acc;
    end

endmodule

// File: rtl/bi_rot_pipe.sv
// Two-stage rotate pipeline for plain or bit-interleaved lanes.
// Stage 1 decodes direction/amount into per-half right rotations and
// registers them; stage 2 rotates and registers the result.
module bi_rot_pipe
    import bi_rot_pkg::*;
#(
    parameter int LANE_W     = 64,
    parameter int INTERLEAVE = 1,
    parameter int TAG_W      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANE_W-1:0]         s_lane,
    input  logic [$clog2(LANE_W)-1:0] s_amt,
    input  logic                      s_dir,
    input  logic [TAG_W-1:0]          s_tag,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANE_W-1:0]         m_lane,
    output logic [TAG_W-1:0]          m_tag
);

    localparam int AW = $clog2(LANE_W);

    logic              adv;
    logic [AW-1:0]     amt_r;
    logic              s1_valid;
    logic [TAG_W-1:0]  s1_tag;
    logic [LANE_W-1:0] rot_lane;

    // The whole pipe moves together; a stalled output freezes both stages.
    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    // Left by r is right by (LANE_W - r) mod LANE_W; the modulo is free in AW bits.
    assign amt_r = (dir_e'(s_dir) == ROT_L) ? AW'(0) - s_amt : s_amt;

    // Stage 1 control: valid bit and tag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= s_valid;
            s1_tag   <= s_tag;
        end
    end

    if (INTERLEAVE != 0) begin : g_il
        localparam int H  = LANE_W / 2;
        localparam int HW = AW - 1;

        logic [HW-1:0] half_amt;
        logic          odd;
        logic [H-1:0]  s1_even, s1_odd;
        logic [HW-1:0] s1_amt_even, s1_amt_odd;
        logic [H-1:0]  rot_even, rot_odd;

        // r = 2s + odd; odd amounts swap halves and the new odd half moves one extra.
        assign half_amt = amt_r[AW-1:1];
        assign odd      = amt_r[0];

        // Stage 1 data: pick source halves and per-half rotate amounts.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s1_even     <= '0;
                s1_odd      <= '0;
                s1_amt_even <= '0;
                s1_amt_odd  <= '0;
            end else if (adv) begin
                s1_even     <= odd ? s_lane[LANE_W-1:H] : s_lane[H-1:0];
                s1_odd      <= odd ? s_lane[H-1:0] : s_lane[LANE_W-1:H];
                s1_amt_even <= half_amt;
                s1_amt_odd  <= half_amt + HW'(odd);
            end
        end

        bi_rot_half #(.W(H)) u_rot_even (
            .din  (s1_even),
            .amt  (s1_amt_even),
            .dout (rot_even)
        );

        bi_rot_half #(.W(H)) u_rot_odd (
            .din  (s1_odd),
            .amt  (s1_amt_odd),
            .dout (rot_odd)
        );

        assign rot_lane = {rot_odd, rot_even};
    end else begin : g_flat
        logic [LANE_W-1:0] s1_lane;
        logic [AW-1:0]     s1_amt;

        // Stage 1 data: operand and a single full-width right amount.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s1_lane <= '0;
                s1_amt  <= '0;
            end else if (adv) begin
                s1_lane <= s_lane;
                s1_amt  <= amt_r;
            end
        end

        bi_rot_half #(.W(LANE_W)) u_rot (
            .din  (s1_lane),
            .amt  (s1_amt),
            .dout (rot_lane)
        );
    end

    // Stage 2: register the rotated lane, its tag and validity.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_lane  <= '0;
            m_tag   <= '0;
        end else if (adv) begin
            m_valid <= s1_valid;
            m_lane  <= rot_lane;
            m_tag   <= s1_tag;
        end
    end

endmodule

// File: tb/tb_bi_rot_pipe.sv
// Self-checking bench: directed vectors, backpressure, mid-stream reset and
// random traffic against a logical-rotation model on two configurations.
module tb_bi_rot_pipe;
    import bi_rot_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // 64-bit interleaved instance
    logic        s_valid, s_ready, s_dir, m_valid, m_ready;
    logic [63:0] s_lane, m_lane;
    logic [5:0]  s_amt;
    logic [3:0]  s_tag, m_tag;

    // 32-bit plain instance
    logic        s_valid2, s_ready2, s_dir2, m_valid2, m_ready2;
    logic [31:0] s_lane2, m_lane2;
    logic [4:0]  s_amt2;
    logic [3:0]  s_tag2, m_tag2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    bi_rot_pipe #(.LANE_W(64), .INTERLEAVE(1), .TAG_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_lane  (s_lane),
        .s_amt   (s_amt),
        .s_dir   (s_dir),
        .s_tag   (s_tag),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_lane  (m_lane),
        .m_tag   (m_tag)
    );

    bi_rot_pipe #(.LANE_W(32), .INTERLEAVE(0), .TAG_W(4)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid2),
        .s_ready (s_ready2),
        .s_lane  (s_lane2),
        .s_amt   (s_amt2),
        .s_dir   (s_dir2),
        .s_tag   (s_tag2),
        .m_valid (m_valid2),
        .m_ready (m_ready2),
        .m_lane  (m_lane2),
        .m_tag   (m_tag2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Logical rotation of the word the lane represents, then back to lane layout.
    function automatic logic [63:0] rot_model(input logic [63:0] lane, input int w,
                                              input bit il, input int r, input bit left);
        logic [MAX_LANE_W-1:0] x, y, o;
        x = il ? deinterleave({64'b0, lane}, w) : {64'b0, lane};
        y = '0;
        for (int j = 0; j < w; j++) begin
            if (left) y[(j + r) % w] = x[j];
            else      y[j] = x[(j + r) % w];
        end
        o = il ? interleave(y, w) : y;
        return o[63:0];
    endfunction

    function automatic logic [63:0] bp_lane(input int t);
        return 64'h0123_4567_89AB_CDEF ^ {8{8'(t + 1)}};
    endfunction

    typedef struct {
        logic [63:0] lane;
        logic [5:0]  amt;
        dir_e        dir;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] lane;
        logic [3:0]  tag;
    } exp_t;

    vec_t vecs[12];
    exp_t q1[$];
    exp_t q2[$];
    int   acc1 = 0;

    // Scoreboard step for random traffic; call #1 after inputs are driven.
    task automatic eval_rand();
        exp_t e;
        if (m_valid && m_ready) begin
            if (q1.size() == 0) check("rnd_unexpected", 64'(m_valid), 64'd0);
            else begin
                e = q1.pop_front();
                check("rnd_lane", m_lane, e.lane);
                check("rnd_tag", 64'(m_tag), 64'(e.tag));
            end
        end
        if (m_valid2 && m_ready2) begin
            if (q2.size() == 0) check("rnd2_unexpected", 64'(m_valid2), 64'd0);
            else begin
                e = q2.pop_front();
                check("rnd2_lane", 64'(m_lane2), e.lane);
                check("rnd2_tag", 64'(m_tag2), 64'(e.tag));
            end
        end
        if (s_valid && s_ready) begin
            e.lane = rot_model(s_lane, 64, 1'b1, int'(s_amt), s_dir);
            e.tag  = s_tag;
            q1.push_back(e);
            acc1++;
        end
        if (s_valid2 && s_ready2) begin
            e.lane = rot_model({32'b0, s_lane2}, 32, 1'b0, int'(s_amt2), s_dir2);
            e.tag  = s_tag2;
            q2.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          next_tx, rx;
        bit          stalled;
        logic [63:0] prev_lane;
        logic [3:0]  prev_tag;

        vecs[0]  = '{64'h0000_0001_0000_0000, 6'd1,  ROT_R, 64'h0000_0000_0000_0001};
        vecs[1]  = '{64'h0000_0001_0000_0000, 6'd3,  ROT_R, 64'h0000_0000_8000_0000};
        vecs[2]  = '{64'h0000_0001_0000_0000, 6'd1,  ROT_L, 64'h0000_0000_0000_0002};
        vecs[3]  = '{64'h0000_0001_0000_0000, 6'd0,  ROT_R, 64'h0000_0001_0000_0000};
        vecs[4]  = '{64'h0000_0001_0000_0000, 6'd0,  ROT_L, 64'h0000_0001_0000_0000};
        vecs[5]  = '{64'h0000_0001_0000_0000, 6'd63, ROT_R, 64'h0000_0000_0000_0002};
        vecs[6]  = '{64'h0000_0000_0000_0001, 6'd1,  ROT_L, 64'h0000_0001_0000_0000};
        vecs[7]  = '{64'h0000_0000_0000_0001, 6'd1,  ROT_R, 64'h8000_0000_0000_0000};
        vecs[8]  = '{64'hFFFF_FFFF_0000_0000, 6'd1,  ROT_R, 64'h0000_0000_FFFF_FFFF};
        vecs[9]  = '{64'h0000_0000_0000_0001, 6'd2,  ROT_L, 64'h0000_0000_0000_0002};
        vecs[10] = '{64'h8000_0000_0000_0000, 6'd1,  ROT_L, 64'h0000_0000_0000_0001};
        vecs[11] = '{64'h0000_0000_0000_0001, 6'd32, ROT_R, 64'h0000_0000_0001_0000};

        s_valid = 1'b0; s_lane = '0; s_amt = '0; s_dir = 1'b0; s_tag = '0; m_ready = 1'b1;
        s_valid2 = 1'b0; s_lane2 = '0; s_amt2 = '0; s_dir2 = 1'b0; s_tag2 = '0; m_ready2 = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_lane", m_lane, 64'd0);
        check("rst_m_tag", 64'(m_tag), 64'd0);
        reset_n = 1'b1;
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);

        // Directed vectors: exact 2-cycle latency, bubbles between words
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_lane = vecs[i].lane; s_amt = vecs[i].amt;
            s_dir = vecs[i].dir; s_tag = 4'(i);
            @(negedge clk);
            s_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), 64'(m_valid), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'd1);
            check($sformatf("vec%0d_lane", i), m_lane, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), 64'(m_tag), 64'(i));
        end

        // Backpressure: tags 0..7, m_ready low for cycles 3..6
        next_tx = 0; rx = 0; stalled = 1'b0; prev_lane = '0; prev_tag = '0;
        for (int c = 0; c < 40 && rx < 8; c++) begin
            @(negedge clk);
            m_ready = !(c >= 3 && c <= 6);
            s_valid = (next_tx < 8);
            s_tag   = 4'(next_tx);
            s_lane  = bp_lane(next_tx);
            s_amt   = 6'((next_tx * 5) % 64);
            s_dir   = 1'(next_tx % 2);
            #1;
            if (stalled) begin
                check("bp_hold_valid", 64'(m_valid), 64'd1);
                check("bp_hold_lane", m_lane, prev_lane);
                check("bp_hold_tag", 64'(m_tag), 64'(prev_tag));
            end
            if (m_valid && !m_ready) check("bp_s_ready", 64'(s_ready), 64'd0);
            if (m_valid && m_ready) begin
                check("bp_tag_order", 64'(m_tag), 64'(rx));
                check("bp_lane", m_lane, rot_model(bp_lane(rx), 64, 1'b1, (rx * 5) % 64, rx % 2 == 1));
                rx++;
            end
            if (s_valid && s_ready) next_tx++;
            stalled   = m_valid && !m_ready;
            prev_lane = m_lane;
            prev_tag  = m_tag;
        end
        check("bp_received", 64'(rx), 64'd8);
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with two words in flight
        s_valid = 1'b1; s_lane = 64'hDEAD_BEEF_0000_0001; s_amt = 6'd5; s_dir = 1'b0; s_tag = 4'hA;
        @(negedge clk);
        s_tag = 4'hB;
        @(negedge clk);
        s_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_tag", 64'(m_tag), 64'd0);
        check("mid_rst_m_lane", m_lane, 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_stale", 64'(m_valid), 64'd0);
        end

        // Random traffic on both configurations with random backpressure
        for (int c = 0; c < 40000 && acc1 < 10000; c++) begin
            @(negedge clk);
            s_valid  = ($urandom_range(0, 3) != 0);
            s_lane   = {$urandom, $urandom};
            s_amt    = 6'($urandom_range(0, 63));
            s_dir    = 1'($urandom_range(0, 1));
            s_tag    = 4'($urandom);
            m_ready  = ($urandom_range(0, 3) != 0);
            s_valid2 = s_valid;
            s_lane2  = $urandom;
            s_amt2   = 5'($urandom_range(0, 31));
            s_dir2   = 1'($urandom_range(0, 1));
            s_tag2   = 4'($urandom);
            m_ready2 = m_ready;
            #1;
            eval_rand();
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s_valid = 1'b0; s_valid2 = 1'b0; m_ready = 1'b1; m_ready2 = 1'b1;
            #1;
            eval_rand();
        end
        check("rnd_accepted", 64'(acc1), 64'd10000);
        check("rnd_drained", 64'(q1.size()), 64'd0);
        check("rnd2_drained", 64'(q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
